// File: rtl/window_frame_buf.sv
// Ping-pong frame buffer: collects clk_en-paced N-sample frames and replays each
// complete frame at full clock rate over valid/ready, flagging dropped and broken frames.
module window_frame_buf #(
  parameter int N          = 1024,
  parameter int DATA_WIDTH = 14
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_clk_en,
  input  logic                         i_di_valid,
  input  logic signed [DATA_WIDTH-1:0] i_di,
  output logic                         o_dout_valid,
  input  logic                         i_dout_ready,
  output logic signed [DATA_WIDTH-1:0] o_dout,
  output logic [$clog2(N)-1:0]         o_dout_idx,
  output logic                         o_dout_last,
  output logic                         o_overflow,
  output logic                         o_abort,
  input  logic                         i_clr_err
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);

  logic signed [DATA_WIDTH-1:0] r_mem [0:2*N-1];
  logic signed [DATA_WIDTH-1:0] r_ram_q;

  logic [AW-1:0] r_wctr;
  logic          r_wbank;
  logic          r_drop;
  logic [1:0]    r_bank_full;
  logic          r_overflow;
  logic          r_abort;

  logic                         r_rbank;
  logic [AW-1:0]                r_rctr;
  logic                         r_all_issued;
  logic                         r_pend;
  logic [AW-1:0]                r_pend_idx;
  logic                         r_skid_valid;
  logic signed [DATA_WIDTH-1:0] r_skid_data;
  logic [AW-1:0]                r_skid_idx;
  logic                         r_dout_valid;
  logic signed [DATA_WIDTH-1:0] r_dout;
  logic [AW-1:0]                r_dout_idx;
  logic                         r_dout_last;

  logic w_wr_en;
  logic w_frame_done;
  logic w_pop;
  logic w_read_done;
  logic w_stay;
  logic w_can_issue;
  logic w_issue;

  // The full/drop decision is taken once at sample 0 and carried for the rest of the frame.
  assign w_wr_en      = i_clk_en && i_di_valid &&
                        ((r_wctr == '0) ? !r_bank_full[r_wbank] : !r_drop);
  assign w_frame_done = i_clk_en && i_di_valid && (r_wctr == LAST_IDX) && !r_drop;

  assign w_pop       = r_dout_valid && i_dout_ready;
  assign w_read_done = w_pop && r_dout_last;
  assign w_stay      = r_dout_valid && !i_dout_ready;
  // Output register, skid entry and the in-flight RAM read hold at most two words.
  assign w_can_issue = !((w_stay && r_skid_valid) || (w_stay && r_pend) ||
                         (r_skid_valid && r_pend));
  assign w_issue     = r_bank_full[r_rbank] && !r_all_issued && w_can_issue;

  always_ff @(posedge i_clk) begin
    if (w_wr_en)
      r_mem[{r_wbank, r_wctr}] <= i_di;
    if (w_issue)
      r_ram_q <= r_mem[{r_rbank, r_rctr}];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wctr     <= '0;
      r_wbank    <= 1'b0;
      r_drop     <= 1'b0;
      r_overflow <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      if (i_clr_err) begin
        r_overflow <= 1'b0;
        r_abort    <= 1'b0;
      end
      if (i_clk_en) begin
        if (i_di_valid) begin
          r_wctr <= r_wctr + IDX_ONE;
          if (r_wctr == '0) begin
            r_drop <= r_bank_full[r_wbank];
            if (r_bank_full[r_wbank])
              r_overflow <= 1'b1;
          end else if (r_wctr == LAST_IDX && !r_drop) begin
            r_wbank <= ~r_wbank;
          end
        end else if (r_wctr != '0) begin
          r_abort <= 1'b1;
          r_wctr  <= '0;
          r_drop  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bank_full <= 2'b00;
    end else begin
      if (w_frame_done)
        r_bank_full[r_wbank] <= 1'b1;
      if (w_read_done)
        r_bank_full[r_rbank] <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rbank      <= 1'b0;
      r_rctr       <= '0;
      r_all_issued <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_idx   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_idx   <= '0;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
      r_dout_idx   <= '0;
      r_dout_last  <= 1'b0;
    end else begin
      r_pend <= w_issue;
      if (w_issue) begin
        r_pend_idx <= r_rctr;
        r_rctr     <= r_rctr + IDX_ONE;
        if (r_rctr == LAST_IDX)
          r_all_issued <= 1'b1;
      end
      if (w_read_done) begin
        r_rbank      <= ~r_rbank;
        r_rctr       <= '0;
        r_all_issued <= 1'b0;
      end
      // The skid entry always drains first so words leave in issue order.
      if (!r_dout_valid || i_dout_ready) begin
        if (r_skid_valid) begin
          r_dout_valid <= 1'b1;
          r_dout       <= r_skid_data;
          r_dout_idx   <= r_skid_idx;
          r_dout_last  <= (r_skid_idx == LAST_IDX);
          r_skid_valid <= r_pend;
          r_skid_data  <= r_ram_q;
          r_skid_idx   <= r_pend_idx;
        end else if (r_pend) begin
          r_dout_valid <= 1'b1;
          r_dout       <= r_ram_q;
          r_dout_idx   <= r_pend_idx;
          r_dout_last  <= (r_pend_idx == LAST_IDX);
        end else begin
          r_dout_valid <= 1'b0;
          r_dout_last  <= 1'b0;
        end
      end else if (r_pend) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= r_ram_q;
        r_skid_idx   <= r_pend_idx;
      end
    end
  end

  assign o_dout_valid = r_dout_valid;
  assign o_dout       = r_dout;
  assign o_dout_idx   = r_dout_idx;
  assign o_dout_last  = r_dout_last;
  assign o_overflow   = r_overflow;
  assign o_abort      = r_abort;

endmodule

// File: tb/tb_window_frame_buf.sv
// Directed bench for window_frame_buf: stimulus pushes expected words into a queue,
// an independent negedge monitor pops and compares every accepted output word.
module tb_window_frame_buf;

  localparam int N  = 1024;
  localparam int DW = 14;
  localparam int AW = $clog2(N);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          last;
  } ExpWord;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clkEn = 1'b0;
  logic          diValid = 1'b0;
  logic [DW-1:0] di = '0;
  logic          doutReady;
  logic          doutValid;
  logic [DW-1:0] dout;
  logic [AW-1:0] doutIdx;
  logic          doutLast;
  logic          overflow;
  logic          abortFlag;
  logic          clrErr = 1'b0;

  logic readyLevel = 1'b1;
  logic readyRandom = 1'b0;

  ExpWord        expQ[$];
  ExpWord        expWord;
  logic          heldValid = 1'b0;
  logic [DW-1:0] heldData;
  logic [AW-1:0] heldIdx;

  int errors = 0;
  int checks = 0;

  window_frame_buf #(.N(N), .DATA_WIDTH(DW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clk_en     (clkEn),
    .i_di_valid   (diValid),
    .i_di         (di),
    .o_dout_valid (doutValid),
    .i_dout_ready (doutReady),
    .o_dout       (dout),
    .o_dout_idx   (doutIdx),
    .o_dout_last  (doutLast),
    .o_overflow   (overflow),
    .o_abort      (abortFlag),
    .i_clr_err    (clrErr)
  );

  always #5 clk = ~clk;

  // Backpressure source: either a fixed level or a fresh coin toss every cycle.
  initial begin
    doutReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      doutReady = readyRandom ? 1'($urandom_range(0, 1)) : readyLevel;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: a held word must stay put, an accepted word must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        heldValid = 1'b0;
      end else begin
        if (heldValid) begin
          checkOutput("holdValid", 32'(doutValid), 32'(1));
          checkOutput("holdData", 32'(dout), 32'(heldData));
          checkOutput("holdIdx", 32'(doutIdx), 32'(heldIdx));
        end
        if (doutValid && doutReady) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedWord: got idx %0d data %0d, expected no word",
                     doutIdx, dout);
          end else begin
            expWord = expQ.pop_front();
            checkOutput("data", 32'(dout), 32'(expWord.data));
            checkOutput("idx", 32'(doutIdx), 32'(expWord.idx));
            checkOutput("last", 32'(doutLast), 32'(expWord.last));
          end
        end
        heldValid = doutValid && !doutReady;
        heldData  = dout;
        heldIdx   = doutIdx;
      end
    end
  end

  function automatic logic [DW-1:0] sampleValue(input int pattern, input int i);
    case (pattern)
      0:       return DW'(i - 512);
      1:       return DW'(~i);
      default: return DW'(i * pattern + 100 * pattern);
    endcase
  endfunction

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [DW-1:0] data, input int gap);
    clkEn   = 1'b1;
    diValid = valid;
    di      = data;
    @(posedge clk);
    #1;
    clkEn   = 1'b0;
    diValid = 1'b0;
    idleCycles(gap);
  endtask

  task automatic sendFrame(input int pattern, input int gap, input bit expectEmit);
    logic [DW-1:0] v;
    for (int i = 0; i < N; i++) begin
      v = sampleValue(pattern, i);
      if (expectEmit)
        expQ.push_back('{data: v, idx: AW'(i), last: 1'(i == N - 1)});
      applyStimulus(1'b1, v, gap);
    end
  endtask

  task automatic sendPartial(input int count, input int gap);
    for (int i = 0; i < count; i++)
      applyStimulus(1'b1, sampleValue(3, i), gap);
  endtask

  task automatic waitDrain(input string name, input int bound);
    int n = 0;
    while ((expQ.size() != 0 || doutValid) && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, 32'(expQ.size()), 32'(0));
    idleCycles(20);
  endtask

  task automatic checkReset();
    @(negedge clk);
    checkOutput("rstValid", 32'(doutValid), 32'(0));
    checkOutput("rstData", 32'(dout), 32'(0));
    checkOutput("rstIdx", 32'(doutIdx), 32'(0));
    checkOutput("rstLast", 32'(doutLast), 32'(0));
    checkOutput("rstOverflow", 32'(overflow), 32'(0));
    checkOutput("rstAbort", 32'(abortFlag), 32'(0));
  endtask

  task automatic pulseClr();
    clrErr = 1'b1;
    @(posedge clk);
    #1;
    clrErr = 1'b0;
  endtask

  initial begin
    int  n;
    bit  found;

    checkReset();
    idleCycles(2);
    rst = 1'b0;
    idleCycles(2);

    $display("[TB] two frames, clk_en every 4th cycle");
    sendFrame(0, 3, 1'b1);
    sendFrame(0, 3, 1'b1);
    waitDrain("drainSlowFrames", 5000);
    checkOutput("noOverflowSlow", 32'(overflow), 32'(0));
    checkOutput("noAbortSlow", 32'(abortFlag), 32'(0));

    $display("[TB] three frames while stalled");
    readyLevel = 1'b0;
    idleCycles(3);
    sendFrame(1, 0, 1'b1);
    sendFrame(2, 0, 1'b1);
    sendFrame(5, 0, 1'b0);
    checkOutput("overflowSet", 32'(overflow), 32'(1));
    readyLevel = 1'b1;
    waitDrain("drainStalled", 6000);
    checkOutput("overflowSticky", 32'(overflow), 32'(1));
    pulseClr();
    checkOutput("overflowCleared", 32'(overflow), 32'(0));

    $display("[TB] broken frame");
    sendPartial(500, 1);
    applyStimulus(1'b0, '0, 1);
    checkOutput("abortSet", 32'(abortFlag), 32'(1));
    idleCycles(50);
    sendFrame(6, 1, 1'b1);
    waitDrain("drainAfterAbort", 5000);
    checkOutput("abortSticky", 32'(abortFlag), 32'(1));
    pulseClr();
    checkOutput("abortCleared", 32'(abortFlag), 32'(0));
    sendPartial(10, 0);
    clrErr = 1'b1;
    applyStimulus(1'b0, '0, 0);
    clrErr = 1'b0;
    checkOutput("abortWinsOverClr", 32'(abortFlag), 32'(1));
    pulseClr();

    $display("[TB] random backpressure");
    readyRandom = 1'b1;
    sendFrame(7, 0, 1'b1);
    idleCycles(8);
    sendFrame(9, 0, 1'b1);
    waitDrain("drainRandomReady", 20000);
    readyRandom = 1'b0;
    readyLevel  = 1'b1;
    idleCycles(3);
    checkOutput("noOverflowRandom", 32'(overflow), 32'(0));

    $display("[TB] reset mid-write and mid-replay");
    sendPartial(700, 0);
    rst = 1'b1;
    checkReset();
    idleCycles(2);
    rst = 1'b0;
    idleCycles(2);
    sendFrame(10, 0, 1'b1);
    waitDrain("drainAfterWriteReset", 5000);
    sendFrame(11, 0, 1'b1);
    n = 0;
    found = 1'b0;
    while (!found && n < 3000) begin
      @(negedge clk);
      n++;
      if (doutValid && doutIdx == AW'(300))
        found = 1'b1;
    end
    checkOutput("reachIdx300", 32'(found), 32'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    expQ.delete();
    checkReset();
    idleCycles(2);
    rst = 1'b0;
    idleCycles(5);
    checkOutput("noReplayAfterReset", 32'(doutValid), 32'(0));
    sendFrame(12, 0, 1'b1);
    waitDrain("drainAfterReplayReset", 5000);

    $display("[TB] full-rate frames");
    sendFrame(13, 0, 1'b1);
    n = 0;
    found = 1'b0;
    while (!found && n < 10) begin
      @(negedge clk);
      n++;
      if (doutValid)
        found = 1'b1;
    end
    $display("[TB] first valid seen at negedge %0d after last write", n);
    checkOutput("firstValidWithin2", 32'(found && n <= 3), 32'(1));
    idleCycles(8);
    sendFrame(14, 0, 1'b1);
    idleCycles(8);
    sendFrame(15, 0, 1'b1);
    waitDrain("drainFullRate", 5000);
    checkOutput("noOverflowFullRate", 32'(overflow), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
